// File: rtl/gate_bist_pkg.sv
// Shared types and reference truth tables for the gate BIST sequencer.
// Truth-table bit i is the expected output when gate_in == i.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StFinish
    } bist_state_e;

    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;

endpackage

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: walks every input vector through a combinational gate, captures its
// truth table and compares it with the expected table latched at start.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   exp_tt,
    output logic [N_IN-1:0]        gate_in,
    input  logic                   gate_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   fail_map,
    output logic [(1<<N_IN)-1:0]   captured_tt
);

    localparam int unsigned        NV         = 1 << N_IN;
    localparam logic [N_IN-1:0]    LAST_VEC   = N_IN'(NV - 1);
    localparam logic [3:0]         SETTLE_CNT = 4'(SETTLE);

    bist_state_e     state;
    logic [N_IN-1:0] vec;
    logic [3:0]      wait_cnt;
    logic [NV-1:0]   exp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            vec         <= '0;
            wait_cnt    <= '0;
            exp_q       <= '0;
            gate_in     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_map    <= '0;
            captured_tt <= '0;
        end else begin
            done <= 1'b0;
            // Abort drops the run without a done pulse; captured_tt keeps partial results.
            if (abort && (state != StIdle)) begin
                state    <= StIdle;
                vec      <= '0;
                wait_cnt <= '0;
                gate_in  <= '0;
                busy     <= 1'b0;
                pass     <= 1'b0;
                fail_map <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start && !abort) begin
                            state       <= StDrive;
                            exp_q       <= exp_tt;
                            vec         <= '0;
                            gate_in     <= '0;
                            wait_cnt    <= SETTLE_CNT;
                            captured_tt <= '0;
                            fail_map    <= '0;
                            pass        <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                    StDrive: begin
                        if (wait_cnt != 4'd0) begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end else begin
                            captured_tt[vec] <= gate_out;
                            if (vec == LAST_VEC) begin
                                state <= StFinish;
                            end else begin
                                vec      <= vec + 1'b1;
                                gate_in  <= vec + 1'b1;
                                wait_cnt <= SETTLE_CNT;
                            end
                        end
                    end
                    StFinish: begin
                        fail_map <= captured_tt ^ exp_q;
                        pass     <= (captured_tt == exp_q);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        gate_in  <= '0;
                        vec      <= '0;
                        state    <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: three instances (SETTLE = 1, 0, 15) each beside a selectable
// gate model; expected results are queued at start and compared when done pulses.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    typedef struct {
        logic [3:0] cap;
        logic [3:0] fmap;
        logic       pass;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = '0;
    logic [2:0] abort = '0;
    logic [2:0] busy, done, pass, gate_out;
    logic [3:0] exp_tt      [3];
    logic [1:0] gate_in     [3];
    logic [3:0] fail_map    [3];
    logic [3:0] captured_tt [3];
    int         sel         [3];  // 0: AND, 1: tied low, 2: OR

    always #5 clk = ~clk;

    always_comb begin
        for (int d = 0; d < 3; d++) begin
            case (sel[d])
                0:       gate_out[d] = &gate_in[d];
                1:       gate_out[d] = 1'b0;
                default: gate_out[d] = |gate_in[d];
            endcase
        end
    end

    gate_bist_ctrl #(.N_IN(2), .SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .exp_tt(exp_tt[0]),
        .gate_in(gate_in[0]), .gate_out(gate_out[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .fail_map(fail_map[0]), .captured_tt(captured_tt[0])
    );
    gate_bist_ctrl #(.N_IN(2), .SETTLE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .exp_tt(exp_tt[1]),
        .gate_in(gate_in[1]), .gate_out(gate_out[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .fail_map(fail_map[1]), .captured_tt(captured_tt[1])
    );
    gate_bist_ctrl #(.N_IN(2), .SETTLE(15)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .exp_tt(exp_tt[2]),
        .gate_in(gate_in[2]), .gate_out(gate_out[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .fail_map(fail_map[2]), .captured_tt(captured_tt[2])
    );

    // Reference truth table of the attached gate model.
    function automatic logic [3:0] model_tt(input int s);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = (s == 0) ? (i == 3) : (s == 1) ? 1'b0 : (i != 0);
        end
        return r;
    endfunction

    function automatic exp_t mk_exp(input int s, input logic [3:0] e, input int settle);
        exp_t x;
        x.cap  = model_tt(s);
        x.fmap = model_tt(s) ^ e;
        x.pass = (model_tt(s) == e);
        x.lat  = 4 * (settle + 1) + 1;
        return x;
    endfunction

    // Pulse start for one edge; returns #1 after the accepting edge.
    task automatic launch(input int d);
        @(posedge clk); #1 start[d] = 1'b1;
        @(posedge clk); #1 start[d] = 1'b0;
    endtask

    // Counts edges from the accept edge until done; ok=0 if the bound expires.
    task automatic wait_done(input int d, input int bound, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            n++;
            if (done[d]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 3'b000) begin bad++; $display("FAIL reset_busy got %b want 000", busy); end
        total++; if (done !== 3'b000) begin bad++; $display("FAIL reset_done got %b want 000", done); end
        total++; if (pass !== 3'b000) begin bad++; $display("FAIL reset_pass got %b want 000", pass); end
        total++; if ({gate_in[0], fail_map[0], captured_tt[0]} !== 10'd0) begin
            bad++; $display("FAIL reset_vectors got gi=%b fm=%b ct=%b want 0", gate_in[0], fail_map[0], captured_tt[0]);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_and_pass();
        exp_t e;
        int   n;
        sel[0] = 0; exp_tt[0] = TT_AND2;
        launch(0);
        sb.push_back(mk_exp(0, TT_AND2, 1));
        exp_tt[0] = TT_OR2;  // must not disturb the running test
        n = 0;
        while (n < 8) begin
            total++; if (gate_in[0] !== 2'(n / 2)) begin bad++; $display("FAIL and_step%0d gate_in got %b want %b", n, gate_in[0], 2'(n / 2)); end
            total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL and_busy%0d got %b want 1", n, busy[0]); end
            @(posedge clk); #1;
            n++;
            if (done[0]) break;
        end
        while (!done[0] && n < 50) begin @(posedge clk); #1; n++; end
        e = sb.pop_front();
        total++; if (!done[0] || n != e.lat) begin bad++; $display("FAIL and_latency got %0d want %0d", n, e.lat); end
        total++; if (captured_tt[0] !== e.cap) begin bad++; $display("FAIL and_captured got %b want %b", captured_tt[0], e.cap); end
        total++; if (fail_map[0] !== e.fmap) begin bad++; $display("FAIL and_fail_map got %b want %b", fail_map[0], e.fmap); end
        total++; if (pass[0] !== e.pass) begin bad++; $display("FAIL and_pass got %b want %b", pass[0], e.pass); end
        total++; if ({busy[0], gate_in[0]} !== 3'b000) begin bad++; $display("FAIL and_idle_out got %b want 000", {busy[0], gate_in[0]}); end
        @(posedge clk); #1;
        total++; if (done[0] !== 1'b0 || pass[0] !== e.pass) begin bad++; $display("FAIL and_done_width got done=%b pass=%b want 0,%b", done[0], pass[0], e.pass); end
    endtask

    task automatic test_mismatch();
        exp_t e;
        int   n;
        bit   ok;
        for (int g = 1; g <= 2; g++) begin
            sel[0] = g; exp_tt[0] = TT_AND2;
            launch(0);
            sb.push_back(mk_exp(g, TT_AND2, 1));
            wait_done(0, 50, n, ok);
            e = sb.pop_front();
            total++; if (!ok || n != e.lat) begin bad++; $display("FAIL mis%0d_latency got %0d want %0d", g, n, e.lat); end
            total++; if (captured_tt[0] !== e.cap) begin bad++; $display("FAIL mis%0d_captured got %b want %b", g, captured_tt[0], e.cap); end
            total++; if (fail_map[0] !== e.fmap) begin bad++; $display("FAIL mis%0d_fail_map got %b want %b", g, fail_map[0], e.fmap); end
            total++; if (pass[0] !== e.pass) begin bad++; $display("FAIL mis%0d_pass got %b want %b", g, pass[0], e.pass); end
        end
    endtask

    task automatic test_settle();
        exp_t e;
        int   n;
        bit   ok;
        for (int d = 1; d <= 2; d++) begin
            sel[d] = 0; exp_tt[d] = TT_AND2;
            launch(d);
            sb.push_back(mk_exp(0, TT_AND2, (d == 1) ? 0 : 15));
            wait_done(d, 200, n, ok);
            e = sb.pop_front();
            total++; if (!ok || n != e.lat) begin bad++; $display("FAIL settle%0d_latency got %0d want %0d", d, n, e.lat); end
            total++; if (captured_tt[d] !== e.cap || pass[d] !== e.pass) begin
                bad++; $display("FAIL settle%0d_result got ct=%b pass=%b want %b,%b", d, captured_tt[d], pass[d], e.cap, e.pass);
            end
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   n;
        int   seen;
        bit   ok;
        sel[0] = 2; exp_tt[0] = TT_OR2;
        launch(0);
        repeat (4) begin @(posedge clk); #1; end
        total++; if (gate_in[0] !== 2'd2) begin bad++; $display("FAIL abort_pre_vec got %b want 10", gate_in[0]); end
        abort[0] = 1'b1;
        @(posedge clk); #1 abort[0] = 1'b0;
        total++; if ({busy[0], gate_in[0], pass[0], fail_map[0]} !== 8'd0) begin
            bad++; $display("FAIL abort_outputs got busy=%b gi=%b pass=%b fm=%b want 0", busy[0], gate_in[0], pass[0], fail_map[0]);
        end
        total++; if (captured_tt[0] !== 4'b0010) begin bad++; $display("FAIL abort_partial got %b want 0010", captured_tt[0]); end
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (done[0] || busy[0]) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_quiet got %0d active cycles want 0", seen); end
        // abort beats start in IDLE
        start[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0; abort[0] = 1'b0;
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL abort_start_idle busy got %b want 0", busy[0]); end
        launch(0);
        sb.push_back(mk_exp(2, TT_OR2, 1));
        wait_done(0, 50, n, ok);
        e = sb.pop_front();
        total++; if (!ok || n != e.lat || pass[0] !== e.pass || captured_tt[0] !== e.cap) begin
            bad++; $display("FAIL abort_rerun got n=%0d pass=%b ct=%b want %0d,%b,%b", n, pass[0], captured_tt[0], e.lat, e.pass, e.cap);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        int   gaps;
        bit   ok;
        sel[0] = 1; exp_tt[0] = TT_AND2;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1;
        sb.push_back(mk_exp(1, TT_AND2, 1));
        wait_done(0, 50, n, ok);
        e = sb.pop_front();
        total++; if (!ok || n != e.lat) begin bad++; $display("FAIL b2b_first_latency got %0d want %0d", n, e.lat); end
        total++; if (fail_map[0] !== e.fmap || pass[0] !== e.pass) begin
            bad++; $display("FAIL b2b_first_result got fm=%b pass=%b want %b,%b", fail_map[0], pass[0], e.fmap, e.pass);
        end
        sel[0] = 0;
        sb.push_back(mk_exp(0, TT_AND2, 1));
        @(posedge clk); #1;
        total++; if (busy[0] !== 1'b1 || fail_map[0] !== 4'b0000 || pass[0] !== 1'b0) begin
            bad++; $display("FAIL b2b_accept got busy=%b fm=%b pass=%b want 1,0000,0", busy[0], fail_map[0], pass[0]);
        end
        gaps = 0;
        n    = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            n++;
            if (done[0]) break;
            if (!busy[0]) gaps++;
        end
        start[0] = 1'b0;
        e = sb.pop_front();
        total++; if (!done[0] || n != e.lat || gaps != 0) begin bad++; $display("FAIL b2b_second_latency got %0d gaps=%0d want %0d,0", n, gaps, e.lat); end
        total++; if (captured_tt[0] !== e.cap || pass[0] !== e.pass) begin
            bad++; $display("FAIL b2b_second_result got ct=%b pass=%b want %b,%b", captured_tt[0], pass[0], e.cap, e.pass);
        end
        @(posedge clk); #1;
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL b2b_no_third got busy=%b want 0", busy[0]); end
    endtask

    task automatic test_reset_mid();
        int seen;
        sel[0] = 2; exp_tt[0] = TT_OR2;
        launch(0);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({busy[0], done[0], pass[0], gate_in[0], fail_map[0], captured_tt[0]} !== 13'd0) begin
            bad++; $display("FAIL rst_mid got busy=%b gi=%b ct=%b want 0", busy[0], gate_in[0], captured_tt[0]);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (busy[0] || done[0]) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_idle got %0d active cycles want 0", seen); end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            sel[d]    = 0;
            exp_tt[d] = '0;
        end
        test_reset();
        test_and_pass();
        test_mismatch();
        test_settle();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
